// File: rtl/ssr_grant_generator.sv
// SSR grant chain head: round-robin arbiter issuing a registered one-hot grant
// that is held until the owner releases it or the hold watchdog expires.
module ssr_grant_generator #(
    parameter int unsigned SSR_BITS   = 2,
    parameter int unsigned HOLD_CNT_W = 8,
    parameter int unsigned MAX_HOLD   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SSR_BITS-1:0]         ssr_req,
    input  logic [SSR_BITS-1:0]         ssr_done,
    output logic [SSR_BITS-1:0]         ssr_bits_out,
    output logic                        grant_valid,
    output logic [$clog2(SSR_BITS)-1:0] grant_idx,
    output logic                        timeout_pulse
);

    localparam int unsigned IDX_W = $clog2(SSR_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [SSR_BITS-1:0]   r_bits;
    logic                  r_valid;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_timeout;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;

    state_t                w_state_nxt;
    logic [SSR_BITS-1:0]   w_bits_nxt;
    logic                  w_valid_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_timeout_nxt;
    logic [IDX_W-1:0]      w_rr_ptr_nxt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_nxt;

    logic                  w_sel_found;
    logic [IDX_W-1:0]      w_sel_idx;
    int unsigned           w_cand;
    logic                  w_release;
    logic                  w_expire;
    logic [IDX_W-1:0]      w_ptr_after;

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = 0;
        for (int unsigned k = 0; k < SSR_BITS; k++) begin
            w_cand = (32'(r_rr_ptr) + k) % SSR_BITS;
            if (!w_sel_found && ssr_req[IDX_W'(w_cand)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(w_cand);
            end
        end
    end

    assign w_release   = ssr_done[r_idx];
    assign w_expire    = (r_hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1));
    assign w_ptr_after = (r_idx == IDX_W'(SSR_BITS - 1)) ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bits     <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_timeout  <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bits     <= w_bits_nxt;
            r_valid    <= w_valid_nxt;
            r_idx      <= w_idx_nxt;
            r_timeout  <= w_timeout_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bits_nxt     = r_bits;
        w_valid_nxt    = r_valid;
        w_idx_nxt      = r_idx;
        w_timeout_nxt  = 1'b0;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            S_IDLE: begin
                w_bits_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = '0;
                if (w_sel_found) begin
                    w_bits_nxt     = SSR_BITS'(1) << w_sel_idx;
                    w_valid_nxt    = 1'b1;
                    w_idx_nxt      = w_sel_idx;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_hold_cnt != HOLD_CNT_W'(MAX_HOLD)) begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_CNT_W'(1);
                end
                // Release by the owner takes priority over the watchdog.
                if (w_release || w_expire) begin
                    w_bits_nxt    = '0;
                    w_valid_nxt   = 1'b0;
                    w_idx_nxt     = '0;
                    w_rr_ptr_nxt  = w_ptr_after;
                    w_timeout_nxt = !w_release;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                w_bits_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_bits_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ssr_bits_out  = r_bits;
    assign grant_valid   = r_valid;
    assign grant_idx     = r_idx;
    assign timeout_pulse = r_timeout;

    a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_bits));
    a_valid   : assert property (@(posedge clk) disable iff (rst) r_valid == (|r_bits));

endmodule

// File: tb/tb_ssr_grant_generator.sv
// Scoreboard bench for ssr_grant_generator (SSR_BITS=4, MAX_HOLD=5).
module tb_ssr_grant_generator;

    logic       clk;
    logic       rst;
    logic [3:0] ssr_req;
    logic [3:0] ssr_done;
    logic [3:0] ssr_bits_out;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout_pulse;

    int n_checks;
    int n_pass;

    typedef struct packed {
        logic [3:0] bits;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    ssr_grant_generator #(
        .SSR_BITS   (4),
        .HOLD_CNT_W (8),
        .MAX_HOLD   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ssr_req       (ssr_req),
        .ssr_done      (ssr_done),
        .ssr_bits_out  (ssr_bits_out),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] b);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".bits"},  32'(ssr_bits_out),  32'(e.bits));
        chk({tag, ".valid"}, 32'(grant_valid),   32'(|e.bits));
        chk({tag, ".idx"},   32'(grant_idx),     32'(idx_of(e.bits)));
        chk({tag, ".tmo"},   32'(timeout_pulse), 32'(e.to));
    endtask

    // Drive one cycle of inputs; expected outputs after the next edge are queued.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] done,
                       input logic [3:0] eb, input logic eto);
        exp_t e;
        ssr_req  = req;
        ssr_done = done;
        sb_q.push_back('{bits: eb, to: eto});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = sb_q.pop_front();
            chk_outputs(tag, e);
        end
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        ssr_req  = '0;
        ssr_done = '0;
        @(posedge clk);
        #1;
        chk_outputs(tag, '{bits: 4'b0000, to: 1'b0});
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] eb;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        ssr_req  = '0;
        ssr_done = '0;

        do_reset("rst0");

        // Single requester: grant, release, gap, re-grant two cycles later.
        cyc("t1_grant",   4'b0001, 4'b0000, 4'b0001, 1'b0);
        cyc("t1_release", 4'b0001, 4'b0001, 4'b0000, 1'b0);
        cyc("t1_gap",     4'b0001, 4'b0000, 4'b0000, 1'b0);
        cyc("t1_regrant", 4'b0001, 4'b0000, 4'b0001, 1'b0);
        cyc("t1_rel2",    4'b0000, 4'b0001, 4'b0000, 1'b0);
        cyc("t1_gap2",    4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc("t1_idle",    4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Round-robin over all four slots, including the wrap back to slot 0.
        do_reset("rst1");
        for (int k = 0; k < 5; k++) begin
            eb = 4'b0001 << (k % 4);
            cyc("t2_grant", 4'b1111, 4'b0000, eb, 1'b0);
            cyc("t2_hold1", 4'b1111, 4'b0000, eb, 1'b0);
            cyc("t2_hold2", 4'b1111, 4'b0000, eb, 1'b0);
            cyc("t2_rel",   4'b1111, eb,      4'b0000, 1'b0);
            cyc("t2_gap",   4'b1111, 4'b0000, 4'b0000, 1'b0);
        end

        // Watchdog: grant visible exactly 5 cycles, then forced revoke with pulse.
        cyc("t3_grant", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc("t3_hold", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        end
        cyc("t3_revoke", 4'b0100, 4'b0000, 4'b0000, 1'b1);
        cyc("t3_gap",    4'b0100, 4'b0000, 4'b0000, 1'b0);

        // Done on the 5th held cycle coincides with expiry: no timeout pulse.
        cyc("t4_grant", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc("t4_hold", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        end
        cyc("t4_both", 4'b0100, 4'b0100, 4'b0000, 1'b0);
        cyc("t4_gap",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc("t4_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Foreign done bits and request drop are ignored while slot 1 is held.
        cyc("t5_grant",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("t5_foreign", 4'b0010, 4'b1101, 4'b0010, 1'b0);
        cyc("t5_reqdrop", 4'b0000, 4'b0000, 4'b0010, 1'b0);
        cyc("t5_foreign2",4'b0000, 4'b1101, 4'b0010, 1'b0);
        cyc("t5_rel",     4'b0000, 4'b0010, 4'b0000, 1'b0);
        cyc("t5_gap",     4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Async reset between edges while busy; pointer restarts at 0.
        cyc("t6_grant", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs("t6_async", '{bits: 4'b0000, to: 1'b0});
        ssr_req = 4'b0000;
        @(posedge clk);
        #1;
        chk_outputs("t6_inrst", '{bits: 4'b0000, to: 1'b0});
        rst = 1'b0;
        cyc("t6_grant3", 4'b1000, 4'b0000, 4'b1000, 1'b0);
        cyc("t6_rel",    4'b1000, 4'b1000, 4'b0000, 1'b0);
        cyc("t6_gap",    4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
